// File: rtl/nlfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nlfsr_pkg
//  Description : Shared types and helpers for the nlfsr_gen RNG block:
//                FSM state encoding, default tap sets for common widths and
//                a configuration sanity-check function.
//  Revision    : 1.0 - initial release
// ============================================================================
package nlfsr_pkg;

    // Two-state control FSM: a single LOAD cycle after reset, then RUN.
    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } nlfsr_state_e;

    // Default tap sets for the widths the RNG datapath uses most.
    localparam int C_W4_TAP_X = 3;
    localparam int C_W4_TAP_A = 2;
    localparam int C_W4_TAP_B = 1;
    localparam int C_W8_TAP_X = 7;
    localparam int C_W8_TAP_A = 6;
    localparam int C_W8_TAP_B = 5;

    // Default tap index k (0 = XOR tap, 1 = first AND tap, 2 = second AND tap).
    // Other widths fall back to the top three state bits.
    function automatic int nlfsr_default_tap(input int width, input int k);
        if (width == 4) begin
            return (k == 0) ? C_W4_TAP_X : (k == 1) ? C_W4_TAP_A : C_W4_TAP_B;
        end else if (width == 8) begin
            return (k == 0) ? C_W8_TAP_X : (k == 1) ? C_W8_TAP_A : C_W8_TAP_B;
        end
        return width - 1 - k;
    endfunction

    // True when width, taps and decoder size form a legal configuration.
    function automatic bit nlfsr_cfg_ok(input int width, input int tap_x,
                                        input int tap_a, input int tap_b,
                                        input int dec_bits);
        bit ok;
        ok = (width >= 3) && (width <= 32);
        ok = ok && (tap_x >= 0) && (tap_x < width);
        ok = ok && (tap_a >= 0) && (tap_a < width);
        ok = ok && (tap_b >= 0) && (tap_b < width);
        ok = ok && (tap_x != tap_a) && (tap_x != tap_b) && (tap_a != tap_b);
        ok = ok && (dec_bits >= 1) && (dec_bits <= width);
        return ok;
    endfunction

endpackage : nlfsr_pkg
`default_nettype wire

// File: rtl/nlfsr_onehot_dec.sv
`default_nettype none
// ============================================================================
//  Module      : nlfsr_onehot_dec
//  Description : Parametrised binary-to-one-hot decoder
//                (DEC_BITS select -> 2**DEC_BITS one-hot lines).
//  Revision    : 1.0 - initial release
// ============================================================================
module nlfsr_onehot_dec
    import nlfsr_pkg::*;
#(
    parameter int DEC_BITS = 3
) (
    input  logic [DEC_BITS-1:0]    sel,
    output logic [2**DEC_BITS-1:0] onehot
);

    // One comparator per output line; exactly one line matches sel.
    for (genvar i = 0; i < 2**DEC_BITS; i++) begin : g_bit
        assign onehot[i] = (sel == DEC_BITS'(i));
    end

endmodule : nlfsr_onehot_dec
`default_nettype wire

// File: rtl/nlfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : nlfsr_gen
//  Description : Parametrised nonlinear feedback shift register for the RNG
//                datapath. Seed load via ready/valid, pull-mode or
//                free-running output, automatic all-zero lock-up recovery and
//                one-hot decode of the low state bits.
//                Optional period monitor enabled by defining the macro
//                NLFSR_PERIOD_MON_EN (default build: monitor absent,
//                period/period_valid tied low).
//  Revision    : 1.0 - initial release
// ============================================================================
module nlfsr_gen
    import nlfsr_pkg::*;
#(
    parameter int               WIDTH        = 8,
    parameter int               TAP_X        = nlfsr_default_tap(WIDTH, 0),
    parameter int               TAP_A        = nlfsr_default_tap(WIDTH, 1),
    parameter int               TAP_B        = nlfsr_default_tap(WIDTH, 2),
    parameter int               DEC_BITS     = 3,
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   seed_valid,
    output logic                   seed_ready,
    input  logic [WIDTH-1:0]       seed,
    input  logic                   free_run,
    output logic                   rd_valid,
    input  logic                   rd_ready,
    output logic [WIDTH-1:0]       rd_data,
    output logic [2**DEC_BITS-1:0] onehot_out,
    output logic                   lockup,
    output logic [WIDTH:0]         period,
    output logic                   period_valid
);

    // Reject illegal tap/width/seed configurations at elaboration.
    if (!nlfsr_cfg_ok(WIDTH, TAP_X, TAP_A, TAP_B, DEC_BITS) || (DEFAULT_SEED == '0)) begin : g_cfg_error
        $error("nlfsr_gen: illegal WIDTH/TAP/DEC_BITS/DEFAULT_SEED configuration");
    end

    nlfsr_state_e     r_fsm;
    logic [WIDTH-1:0] r_state;
    logic             r_rd_valid;
    logic             r_seed_ready;
    logic             r_lockup;

    logic             w_fb;
    logic [WIDTH-1:0] w_step_val;
    logic             w_run;
    logic             w_seed_hs;
    logic             w_step;
    logic             w_zero_seed;
    logic [WIDTH-1:0] w_load_val;
    logic             w_lock;

    assign w_fb        = r_state[TAP_X] ^ (r_state[TAP_A] & r_state[TAP_B]);
    assign w_step_val  = {r_state[WIDTH-2:0], w_fb};
    assign w_run       = (r_fsm == ST_RUN);
    // seed_ready is only high in RUN, so a handshake implies RUN.
    assign w_seed_hs   = seed_valid & r_seed_ready;
    // free_run and an output transfer in the same cycle still give one step.
    assign w_step      = w_run & (free_run | (r_rd_valid & rd_ready));
    assign w_zero_seed = (seed == '0);
    assign w_load_val  = w_zero_seed ? DEFAULT_SEED : seed;
    // A seed handshake overrides recovery: the seed is already a fresh start.
    assign w_lock      = w_run & (r_state == '0) & ~w_seed_hs;

    // Control FSM and state register: seed > lock-up recovery > step.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm        <= ST_LOAD;
            r_state      <= DEFAULT_SEED;
            r_rd_valid   <= 1'b0;
            r_seed_ready <= 1'b0;
            r_lockup     <= 1'b0;
        end else begin
            r_lockup <= 1'b0;
            case (r_fsm)
                ST_LOAD: begin
                    r_fsm        <= ST_RUN;
                    r_rd_valid   <= 1'b1;
                    r_seed_ready <= 1'b1;
                end
                ST_RUN: begin
                    r_rd_valid   <= 1'b1;
                    r_seed_ready <= 1'b1;
                    if (w_seed_hs) begin
                        r_state  <= w_load_val;
                        r_lockup <= w_zero_seed;
                    end else if (w_lock) begin
                        r_state  <= DEFAULT_SEED;
                        r_lockup <= 1'b1;
                    end else if (w_step) begin
                        r_state  <= w_step_val;
                    end
                end
                default: begin
                    r_fsm <= ST_LOAD;
                end
            endcase
        end
    end

    assign rd_data    = r_state;
    assign rd_valid   = r_rd_valid;
    assign seed_ready = r_seed_ready;
    assign lockup     = r_lockup;

    nlfsr_onehot_dec #(
        .DEC_BITS (DEC_BITS)
    ) u_dec (
        .sel    (r_state[DEC_BITS-1:0]),
        .onehot (onehot_out)
    );

`ifdef NLFSR_PERIOD_MON_EN
    localparam logic [WIDTH:0] C_CNT_ONE = 1;

    logic [WIDTH:0]   r_cnt;
    logic [WIDTH:0]   r_period;
    logic [WIDTH-1:0] r_ref;
    logic             r_period_valid;

    // Period monitor: count steps since the reference state was last seen.
    // A saturated count means the reference was lost; its return clears the
    // counter without reporting a bogus period.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_period       <= '0;
            r_ref          <= DEFAULT_SEED;
            r_period_valid <= 1'b0;
        end else begin
            r_period_valid <= 1'b0;
            if (w_seed_hs) begin
                r_cnt <= '0;
                r_ref <= w_load_val;
            end else if (w_lock) begin
                r_cnt <= '0;
                r_ref <= DEFAULT_SEED;
            end else if (w_step) begin
                if (w_step_val == r_ref) begin
                    r_cnt <= '0;
                    if (r_cnt != '1) begin
                        r_period       <= r_cnt + C_CNT_ONE;
                        r_period_valid <= 1'b1;
                    end
                end else if (r_cnt != '1) begin
                    r_cnt <= r_cnt + C_CNT_ONE;
                end
            end
        end
    end

    assign period       = r_period;
    assign period_valid = r_period_valid;
`else
    assign period       = '0;
    assign period_valid = 1'b0;
`endif

endmodule : nlfsr_gen
`default_nettype wire

// File: tb/tb_nlfsr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nlfsr_gen
//  Description : Self-checking bench for nlfsr_gen (WIDTH=4, taps 3/2/1,
//                DEC_BITS=2) plus a second instance with taps that can reach
//                the all-zero state, used for lock-up recovery.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nlfsr_gen;

`ifdef NLFSR_PERIOD_MON_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    typedef struct {
        logic [3:0] data;
        logic       pv;
        logic [4:0] per;
    } exp_t;

    logic       clk;
    logic       reset;

    // Main instance
    logic       seed_valid, seed_ready, free_run, rd_valid, rd_ready, lockup, period_valid;
    logic [3:0] seed, rd_data, onehot_out;
    logic [4:0] period;

    // Hostile-tap instance (feedback s0 ^ (s1 & s2): 1000 steps to 0000)
    logic       h_seed_valid, h_seed_ready, h_free_run, h_rd_valid, h_rd_ready, h_lockup, h_period_valid;
    logic [3:0] h_seed, h_rd_data;
    logic [7:0] h_onehot_out;
    logic [4:0] h_period;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb[$];

    nlfsr_gen #(
        .WIDTH(4), .TAP_X(3), .TAP_A(2), .TAP_B(1), .DEC_BITS(2), .DEFAULT_SEED(4'b0001)
    ) u_dut (
        .clk(clk), .reset(reset), .seed_valid(seed_valid), .seed_ready(seed_ready),
        .seed(seed), .free_run(free_run), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_data(rd_data), .onehot_out(onehot_out), .lockup(lockup),
        .period(period), .period_valid(period_valid)
    );

    nlfsr_gen #(
        .WIDTH(4), .TAP_X(0), .TAP_A(1), .TAP_B(2), .DEC_BITS(3), .DEFAULT_SEED(4'b0001)
    ) u_dut_h (
        .clk(clk), .reset(reset), .seed_valid(h_seed_valid), .seed_ready(h_seed_ready),
        .seed(h_seed), .free_run(h_free_run), .rd_valid(h_rd_valid), .rd_ready(h_rd_ready),
        .rd_data(h_rd_data), .onehot_out(h_onehot_out), .lockup(h_lockup),
        .period(h_period), .period_valid(h_period_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [3:0] d, input logic pv, input logic [4:0] per);
        exp_t e;
        e.data = d;
        e.pv   = MON ? pv  : 1'b0;
        e.per  = MON ? per : 5'd0;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare against what the DUT shows now.
    task automatic pop_check(input string tag);
        exp_t       e;
        logic [3:0] oh;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e  = sb.pop_front();
            oh = 4'b0001 << e.data[1:0];
            chk({tag, "_data"},   32'(rd_data),      32'(e.data));
            chk({tag, "_onehot"}, 32'(onehot_out),   32'(oh));
            chk({tag, "_pv"},     32'(period_valid), 32'(e.pv));
            chk({tag, "_period"}, 32'(period),       32'(e.per));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rd_valid"},   32'(rd_valid),     32'd0);
        chk({tag, "_seed_ready"}, 32'(seed_ready),   32'd0);
        chk({tag, "_lockup"},     32'(lockup),       32'd0);
        chk({tag, "_rd_data"},    32'(rd_data),      32'h1);
        chk({tag, "_onehot"},     32'(onehot_out),   32'h2);
        chk({tag, "_period"},     32'(period),       32'd0);
        chk({tag, "_pv"},         32'(period_valid), 32'd0);
    endtask

    task automatic load_seed(input logic [3:0] s);
        seed_valid = 1'b1;
        seed       = s;
        tick();
        seed_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] seq9 [9];
        logic       rdy4 [4];
        seq9 = '{4'b1101, 4'b1011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1001, 4'b0011, 4'b0110};
        rdy4 = '{1'b1, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; seed_valid = 1'b0; seed = 4'd0; free_run = 1'b0; rd_ready = 1'b0;
        h_seed_valid = 1'b0; h_seed = 4'd0; h_free_run = 1'b0; h_rd_ready = 1'b0;
        tick(); tick();
        check_reset_vals("rst");

        // ---- LOAD for one cycle, then free-running sequence from DEFAULT_SEED
        reset    = 1'b0;
        free_run = 1'b1;
        chk("load_rd_valid", 32'(rd_valid), 32'd0);
        tick();
        chk("run_rd_valid",   32'(rd_valid),   32'd1);
        chk("run_seed_ready", 32'(seed_ready), 32'd1);
        chk("run_rd_data",    32'(rd_data),    32'h1);
        push_exp(4'b0010, 1'b0, 5'd0);
        push_exp(4'b0100, 1'b0, 5'd0);
        push_exp(4'b1000, 1'b0, 5'd0);
        push_exp(4'b0001, 1'b1, 5'd4);
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) free_run = 1'b0;
            pop_check("seq4");
        end

        // ---- seed 0110, free-run through its 9-state cycle
        load_seed(4'b0110);
        chk("seed_rd_data", 32'(rd_data), 32'h6);
        chk("seed_lockup",  32'(lockup),  32'd0);
        free_run = 1'b1;
        for (int i = 0; i < 9; i++) push_exp(seq9[i], (i == 8), (i == 8) ? 5'd9 : 5'd4);
        for (int i = 0; i < 9; i++) begin
            tick();
            if (i == 8) free_run = 1'b0;
            pop_check("seq9");
        end

        // ---- pull mode: advance only on rd_valid & rd_ready
        load_seed(4'b0001);
        chk("pull_start", 32'(rd_data), 32'h1);
        push_exp(4'b0010, 1'b0, 5'd9);
        push_exp(4'b0010, 1'b0, 5'd9);
        push_exp(4'b0010, 1'b0, 5'd9);
        push_exp(4'b0100, 1'b0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            rd_ready = rdy4[i];
            tick();
            pop_check("pull");
        end
        rd_ready = 1'b0;

        // ---- zero seed: substitute DEFAULT_SEED and pulse lockup
        load_seed(4'b0000);
        chk("zseed_rd_data",    32'(rd_data),    32'h1);
        chk("zseed_lockup",     32'(lockup),     32'd1);
        chk("zseed_seed_ready", 32'(seed_ready), 32'd1);
        tick();
        chk("zseed_lockup_end", 32'(lockup),     32'd0);

        // ---- hostile taps: reach all-zero, recover to DEFAULT_SEED
        h_seed_valid = 1'b1; h_seed = 4'b1000;
        tick();
        h_seed_valid = 1'b0;
        chk("h_seed",       32'(h_rd_data),    32'h8);
        chk("h_rd_valid",   32'(h_rd_valid),   32'd1);
        chk("h_seed_ready", 32'(h_seed_ready), 32'd1);
        h_free_run = 1'b1;
        tick();
        h_free_run = 1'b0;
        chk("h_zero",       32'(h_rd_data), 32'h0);
        chk("h_zero_lock",  32'(h_lockup),  32'd0);
        tick();
        chk("h_recover",      32'(h_rd_data), 32'h1);
        chk("h_recover_lock", 32'(h_lockup),  32'd1);
        tick();
        chk("h_recover_end",  32'(h_lockup),  32'd0);

        // zero state and a seed offer in the same cycle: seed wins
        h_seed_valid = 1'b1; h_seed = 4'b1000;
        tick();
        h_seed_valid = 1'b0;
        h_free_run   = 1'b1;
        tick();
        h_free_run = 1'b0;
        chk("h_zero2", 32'(h_rd_data), 32'h0);
        h_seed_valid = 1'b1; h_seed = 4'b0101;
        tick();
        h_seed_valid = 1'b0;
        chk("h_seed_wins",   32'(h_rd_data),    32'h5);
        chk("h_seed_onehot", 32'(h_onehot_out), 32'h20);

        // ---- reset during a transfer and a seed handshake
        rd_ready = 1'b1;
        tick();
        chk("pre_rst_data", 32'(rd_data), 32'h2);
        seed_valid = 1'b1; seed = 4'b0110; rd_ready = 1'b1; reset = 1'b1;
        tick();
        check_reset_vals("mid_rst");
        seed_valid = 1'b0; rd_ready = 1'b0; reset = 1'b0;
        tick();
        chk("post_rst_rd_valid", 32'(rd_valid), 32'd1);
        chk("post_rst_rd_data",  32'(rd_data),  32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_nlfsr_gen
`default_nettype wire
